fft_quad_reorder: RTL and testbench

- Sits downstream of the 4-lane quad FFT combiner and consumes its output bus: four 64-bit bins per beat, a per-beat index k, a valid strobe and a last strobe.
- Lane j at index k carries bin j*2^K_WIDTH + k.
- The block ping-pong buffers whole frames, reorders them into natural bin order 0..N-1, and streams them out as a single-lane AXI-Stream with backpressure toward the DMA/packetizer.
- The upstream side has no backpressure, so frames that cannot be buffered are dropped whole and counted.

---
 rtl/fft_quad_reorder_if.sv | 44 ++++
 rtl/fft_quad_reorder.sv | 224 ++++++++++++++++++++++
 tb/tb_fft_quad_reorder.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_quad_reorder_if.sv
// Bus bundle for the quad-FFT reorder block: the 4-lane combiner output it
// consumes and the single-lane AXI-Stream it produces.
//
// Handshake semantics:
//   - Upstream: a beat is taken on every clock edge where s_valid is high.
//     There is no ready; s_last marks the final beat of a frame and only
//     counts together with s_valid.
//   - Downstream: a beat transfers on a clock edge where m_tvalid and
//     m_tready are both high. Once m_tvalid rises it stays high, and
//     m_tdata/m_tuser/m_tlast stay stable, until that transfer happens.
//
// The slave modport is the reorder block itself; the master modport is the
// surrounding environment (combiner driving the input lanes, sink driving
// m_tready).
interface fft_quad_reorder_if #(
    parameter int K_WIDTH    = 14,
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] data_in_0;
    logic [DATA_WIDTH-1:0] data_in_1;
    logic [DATA_WIDTH-1:0] data_in_2;
    logic [DATA_WIDTH-1:0] data_in_3;
    logic [K_WIDTH-1:0]    k;
    logic                  s_valid;
    logic                  s_last;

    logic [DATA_WIDTH-1:0] m_tdata;
    logic [K_WIDTH+1:0]    m_tuser;
    logic                  m_tvalid;
    logic                  m_tready;
    logic                  m_tlast;

    modport master (
        output data_in_0, data_in_1, data_in_2, data_in_3, k, s_valid, s_last,
        output m_tready,
        input  m_tdata, m_tuser, m_tvalid, m_tlast
    );

    modport slave (
        input  data_in_0, data_in_1, data_in_2, data_in_3, k, s_valid, s_last,
        input  m_tready,
        output m_tdata, m_tuser, m_tvalid, m_tlast
    );
endinterface

// File: rtl/fft_quad_reorder.sv
// Ping-pong frame buffer that turns the 4-lane quad FFT combiner output into a
// natural-order single-lane AXI-Stream. Frames arriving while both banks are
// occupied are dropped whole and counted.
module fft_quad_reorder #(
    parameter int K_WIDTH    = 14,
    parameter int DATA_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 resetn,
    fft_quad_reorder_if.slave    bus,
    input  logic                 clr,
    output logic                 overflow,
    output logic [15:0]          drop_count,
    output logic [1:0]           o_wr_state,
    output logic                 o_rd_state
);
    localparam int BW    = K_WIDTH + 2;          // bin number width
    localparam int AW    = K_WIDTH + 1;          // lane RAM address width {bank, k}
    localparam int DEPTH = 2 ** AW;
    localparam logic [BW-1:0] LAST_BIN = {BW{1'b1}};

    typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_WRITE = 2'd1, WR_DROP = 2'd2} wr_state_t;
    typedef enum logic {RD_IDLE = 1'b0, RD_STREAM = 1'b1} rd_state_t;

    // Write side
    wr_state_t r_wr_state, w_wr_next;
    logic      r_wbank;
    logic [1:0] r_full, w_full_eff, w_full_set, w_full_clr;
    logic      w_we, w_drop_done;

    // Read side
    rd_state_t r_rd_state, w_rd_next;
    logic      r_rbank;
    logic [BW-1:0] r_b;
    logic      r_issued_all;
    logic      w_issue, w_frame_done, w_pop, w_credit;
    logic [2:0] w_occ;
    logic [1:0] w_rd_lane;
    logic [AW-1:0] w_rd_addr;

    // Storage and output pipeline
    logic [DATA_WIDTH-1:0] r_mem [4][DEPTH];
    logic [DATA_WIDTH-1:0] r_ram_q;
    logic [BW-1:0]         r_ram_user;
    logic                  r_ram_vld;
    logic [DATA_WIDTH-1:0] r_sk_data [2];
    logic [BW-1:0]         r_sk_user [2];
    logic [1:0]            r_sk_cnt, w_sk_after;

    assign bus.m_tvalid = (r_sk_cnt != 2'd0);
    assign bus.m_tdata  = r_sk_data[0];
    assign bus.m_tuser  = r_sk_user[0];
    assign bus.m_tlast  = bus.m_tvalid && (r_sk_user[0] == LAST_BIN);
    assign o_wr_state   = r_wr_state;
    assign o_rd_state   = r_rd_state;

    assign w_pop        = bus.m_tvalid & bus.m_tready;
    assign w_frame_done = w_pop & bus.m_tlast;
    // The reader frees its bank when the final bin leaves; the writer sees
    // that release in the same cycle so a frame starting right then is kept.
    assign w_full_clr   = {w_frame_done & r_rbank, w_frame_done & ~r_rbank};
    assign w_full_eff   = r_full & ~w_full_clr;

    // A read may be issued only if the RAM register plus skid entries,
    // after this cycle's pop, leave room for it.
    assign w_occ      = {1'b0, r_sk_cnt} + {2'b00, r_ram_vld} - {2'b00, w_pop};
    assign w_credit   = (w_occ < 3'd2);
    assign w_rd_lane  = r_b[K_WIDTH+1:K_WIDTH];
    assign w_rd_addr  = {r_rbank, r_b[K_WIDTH-1:0]};
    assign w_sk_after = r_sk_cnt - {1'b0, w_pop};

    // Write FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_wr_state <= WR_IDLE;
        else         r_wr_state <= w_wr_next;
    end

    // Write FSM next state
    always_comb begin
        w_wr_next = r_wr_state;
        case (r_wr_state)
            WR_IDLE:  if (bus.s_valid && !bus.s_last)
                          w_wr_next = w_full_eff[r_wbank] ? WR_DROP : WR_WRITE;
            WR_WRITE: if (bus.s_valid && bus.s_last) w_wr_next = WR_IDLE;
            WR_DROP:  if (bus.s_valid && bus.s_last) w_wr_next = WR_IDLE;
            default:  w_wr_next = WR_IDLE;
        endcase
    end

    // Write FSM outputs: lane write enable, bank-full set, drop completion
    always_comb begin
        w_we        = 1'b0;
        w_full_set  = 2'b00;
        w_drop_done = 1'b0;
        case (r_wr_state)
            WR_IDLE: begin
                if (bus.s_valid) begin
                    if (w_full_eff[r_wbank]) begin
                        w_drop_done = bus.s_last;
                    end else begin
                        w_we = 1'b1;
                        if (bus.s_last) w_full_set[r_wbank] = 1'b1;
                    end
                end
            end
            WR_WRITE: begin
                w_we = bus.s_valid;
                if (bus.s_valid && bus.s_last) w_full_set[r_wbank] = 1'b1;
            end
            WR_DROP: w_drop_done = bus.s_valid & bus.s_last;
            default: ;
        endcase
    end

    // Bank bookkeeping: set by the writer, cleared by the reader, never the same bank
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_full  <= 2'b00;
            r_wbank <= 1'b0;
        end else begin
            r_full <= w_full_eff | w_full_set;
            if (|w_full_set) r_wbank <= ~r_wbank;
        end
    end

    // Drop statistics; clr takes priority over a drop finishing in the same cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow   <= 1'b0;
            drop_count <= 16'd0;
        end else if (clr) begin
            overflow   <= 1'b0;
            drop_count <= 16'd0;
        end else if (w_drop_done) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end

    // Lane RAMs: all four lanes written per beat, one lane read per bin
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[0][{r_wbank, bus.k}] <= bus.data_in_0;
            r_mem[1][{r_wbank, bus.k}] <= bus.data_in_1;
            r_mem[2][{r_wbank, bus.k}] <= bus.data_in_2;
            r_mem[3][{r_wbank, bus.k}] <= bus.data_in_3;
        end
        if (w_issue) r_ram_q <= r_mem[w_rd_lane][w_rd_addr];
    end

    // Read FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_rd_state <= RD_IDLE;
        else         r_rd_state <= w_rd_next;
    end

    // Read FSM next state
    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            RD_IDLE:   if (r_full[r_rbank] && w_credit) w_rd_next = RD_STREAM;
            RD_STREAM: if (w_frame_done) w_rd_next = RD_IDLE;
            default:   w_rd_next = RD_IDLE;
        endcase
    end

    // Read FSM outputs: bin 0 is issued straight from IDLE to keep frame gaps short
    always_comb begin
        w_issue = 1'b0;
        case (r_rd_state)
            RD_IDLE:   w_issue = r_full[r_rbank] & w_credit;
            RD_STREAM: w_issue = ~r_issued_all & w_credit;
            default:   w_issue = 1'b0;
        endcase
    end

    // Bin counter, read bank and RAM-output valid/tag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_b          <= '0;
            r_issued_all <= 1'b0;
            r_rbank      <= 1'b0;
            r_ram_vld    <= 1'b0;
            r_ram_user   <= '0;
        end else begin
            r_ram_vld <= w_issue;
            if (w_issue) begin
                r_ram_user <= r_b;
                r_b        <= r_b + 1'b1;
                if (r_b == LAST_BIN) r_issued_all <= 1'b1;
            end
            if (w_frame_done) begin
                r_rbank      <= ~r_rbank;
                r_issued_all <= 1'b0;
            end
        end
    end

    // Two-entry skid buffer; entry 0 is the presented beat
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 2; i++) begin
                r_sk_data[i] <= '0;
                r_sk_user[i] <= '0;
            end
            r_sk_cnt <= 2'd0;
        end else begin
            if (w_pop) begin
                r_sk_data[0] <= r_sk_data[1];
                r_sk_user[0] <= r_sk_user[1];
            end
            if (r_ram_vld) begin
                if (w_sk_after == 2'd0) begin
                    r_sk_data[0] <= r_ram_q;
                    r_sk_user[0] <= r_ram_user;
                end else begin
                    r_sk_data[1] <= r_ram_q;
                    r_sk_user[1] <= r_ram_user;
                end
            end
            r_sk_cnt <= w_sk_after + {1'b0, r_ram_vld};
        end
    end
endmodule

// File: tb/tb_fft_quad_reorder.sv
// Directed bench for fft_quad_reorder with K_WIDTH=2 (N=16). Lane j at index k
// carries {tag, j*4+k}, so bin b of a frame must come out as {tag, b}.
module tb_fft_quad_reorder;
    localparam int KW = 2;
    localparam int DW = 64;
    localparam int N  = 16;
    localparam int EW = 1 + 4 + DW;   // {last, user, data}

    logic        clk = 1'b0;
    logic        resetn;
    logic        clr;
    logic        overflow;
    logic [15:0] drop_count;
    logic [1:0]  wr_state;
    logic        rd_state;

    int n_cmp = 0;
    int n_err = 0;
    int ready_mode = 0;   // 0: always ready, 1: toggle each cycle, 2: held low

    logic [EW-1:0] exp_q[$];

    fft_quad_reorder_if #(.K_WIDTH(KW), .DATA_WIDTH(DW)) bus ();

    fft_quad_reorder #(.K_WIDTH(KW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (bus),
        .clr        (clr),
        .overflow   (overflow),
        .drop_count (drop_count),
        .o_wr_state (wr_state),
        .o_rd_state (rd_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- watchdog ----------------
    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tvalid"}, 64'(bus.m_tvalid), 64'd0);
        check({tag, "_tlast"},  64'(bus.m_tlast),  64'd0);
        check({tag, "_tdata"},  bus.m_tdata,       64'd0);
        check({tag, "_tuser"},  64'(bus.m_tuser),  64'd0);
        check({tag, "_overflow"}, 64'(overflow),   64'd0);
        check({tag, "_drop_count"}, 64'(drop_count), 64'd0);
        check({tag, "_wr_state"}, 64'(wr_state),   64'd0);
        check({tag, "_rd_state"}, 64'(rd_state),   64'd0);
    endtask

    // ---------------- ready driver ----------------
    initial begin
        bus.m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.m_tready = 1'b1;
                1:       bus.m_tready = ~bus.m_tready;
                default: bus.m_tready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic          stalled = 1'b0;
    logic [DW-1:0] held_data;
    logic [3:0]    held_user;
    logic          held_last;

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!resetn) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_tvalid", 64'(bus.m_tvalid), 64'd1);
                check("stall_tdata",  bus.m_tdata,       held_data);
                check("stall_tuser",  64'(bus.m_tuser),  64'(held_user));
                check("stall_tlast",  64'(bus.m_tlast),  64'(held_last));
            end
            if (bus.m_tvalid && bus.m_tready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_beat: got tuser %0d tdata %h expected no beat",
                             bus.m_tuser, bus.m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("tdata", bus.m_tdata,      e[DW-1:0]);
                    check("tuser", 64'(bus.m_tuser), 64'(e[DW+3:DW]));
                    check("tlast", 64'(bus.m_tlast), 64'(e[EW-1]));
                end
            end
            stalled   = bus.m_tvalid && !bus.m_tready;
            held_data = bus.m_tdata;
            held_user = bus.m_tuser;
            held_last = bus.m_tlast;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_frame(input logic [31:0] tag);
        for (int b = 0; b < N; b++)
            exp_q.push_back({(b == N - 1), 4'(b), tag, 32'(b)});
    endtask

    task automatic drive_beat(input logic [31:0] tag, input int kk, input logic last);
        @(posedge clk);
        #1;
        bus.k         = KW'(kk);
        bus.data_in_0 = {tag, 32'(kk)};
        bus.data_in_1 = {tag, 32'(4 + kk)};
        bus.data_in_2 = {tag, 32'(8 + kk)};
        bus.data_in_3 = {tag, 32'(12 + kk)};
        bus.s_valid   = 1'b1;
        bus.s_last    = last;
    endtask

    task automatic idle_inputs();
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    // bitrev=1 sends k in 0,2,1,3 order; kept=1 means the frame should be buffered
    task automatic send_frame(input logic [31:0] tag, input bit bitrev, input bit kept);
        int order_nat[4] = '{0, 1, 2, 3};
        int order_rev[4] = '{0, 2, 1, 3};
        for (int i = 0; i < 4; i++) begin
            drive_beat(tag, bitrev ? order_rev[i] : order_nat[i], (i == 3));
            if (i == 3 && kept) push_frame(tag);
        end
        idle_inputs();
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        repeat (20) @(posedge clk);
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        #1;
        exp_q.delete();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit found;
        resetn        = 1'b0;
        clr           = 1'b0;
        bus.s_valid   = 1'b0;
        bus.s_last    = 1'b0;
        bus.k         = '0;
        bus.data_in_0 = '0;
        bus.data_in_1 = '0;
        bus.data_in_2 = '0;
        bus.data_in_3 = '0;
        #1;
        check_reset_outputs("por");
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;

        // Natural order, latency and no bubbles with ready held high
        send_frame(32'd0, 1'b0, 1'b1);
        found = 1'b0;
        for (int n = 1; n <= 3 && !found; n++) begin
            @(posedge clk);
            #1;
            if (bus.m_tvalid) found = 1'b1;
        end
        check("first_valid_within_3", 64'(found), 64'd1);
        for (int i = 1; i < N; i++) begin
            @(posedge clk);
            #1;
            check("no_bubble", 64'(bus.m_tvalid), 64'd1);
        end
        wait_drain("natural");

        // Bit-reversed k order
        send_frame(32'd1, 1'b1, 1'b1);
        wait_drain("bitrev");

        // 50% backpressure
        ready_mode = 1;
        send_frame(32'd2, 1'b0, 1'b1);
        wait_drain("backpressure");
        ready_mode = 0;

        // Overflow: A and B buffered, C dropped while the sink stalls
        ready_mode = 2;
        repeat (2) @(posedge clk);
        send_frame(32'hA, 1'b0, 1'b1);
        send_frame(32'hB, 1'b0, 1'b1);
        send_frame(32'hC, 1'b1, 1'b0);
        check("ovf_overflow",   64'(overflow),   64'd1);
        check("ovf_drop_count", 64'(drop_count), 64'd1);
        ready_mode = 0;
        wait_drain("overflow");
        repeat (30) @(posedge clk);

        // clr alone
        @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("clr_overflow",   64'(overflow),   64'd0);
        check("clr_drop_count", 64'(drop_count), 64'd0);

        // Saturation: fill both banks, then 65537 one-beat dropped frames
        ready_mode = 2;
        repeat (2) @(posedge clk);
        send_frame(32'hD, 1'b0, 1'b1);
        send_frame(32'hE, 1'b1, 1'b1);
        for (int i = 0; i < 65537; i++) drive_beat(32'hF, 0, 1'b1);
        idle_inputs();
        check("sat_drop_count", 64'(drop_count), 64'hFFFF);
        check("sat_overflow",   64'(overflow),   64'd1);
        // clr coinciding with another completed drop
        drive_beat(32'hF, 0, 1'b1);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr         = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        check("clr_wins_overflow",   64'(overflow),   64'd0);
        check("clr_wins_drop_count", 64'(drop_count), 64'd0);
        ready_mode = 0;
        wait_drain("saturation");

        // Reset while the k=2 beat of a frame is being written
        drive_beat(32'h8, 0, 1'b0);
        drive_beat(32'h8, 1, 1'b0);
        drive_beat(32'h8, 2, 1'b0);
        #2;
        apply_reset();
        check_reset_outputs("rst_write");
        release_reset();
        repeat (10) @(posedge clk);

        // Reset while bin 7 is being presented
        send_frame(32'h9, 1'b0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #1;
            if (bus.m_tvalid && bus.m_tuser == 4'd7) found = 1'b1;
        end
        check("saw_bin7", 64'(found), 64'd1);
        apply_reset();
        check_reset_outputs("rst_stream");
        release_reset();
        repeat (10) @(posedge clk);
        check("post_reset_quiet", 64'(bus.m_tvalid), 64'd0);

        // Fresh frame after reset must stream a clean 0..15
        send_frame(32'd0, 1'b0, 1'b1);
        wait_drain("fresh");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
